// File: rtl/cpu_pkg.sv
// Shared encodings for the ALU issue path: instruction classes, function codes,
// forwarding select codes, scoreboard entry and issue-controller state type.
package cpu_pkg;

    localparam logic [1:0]  CLS_R    = 2'b00;
    localparam logic [1:0]  CLS_LI   = 2'b01;
    localparam logic [1:0]  CLS_BR   = 2'b10;

    localparam logic [4:0]  FUNC_ADD = 5'b00010;
    localparam logic [4:0]  FUNC_CMP = 5'b00100;
    localparam logic [4:0]  FUNC_MLT = 5'b00101;

    localparam logic [2:0]  BR_BNZ   = 3'b001;
    localparam logic [2:0]  BR_BZ    = 3'b010;

    localparam logic [15:0] NOP_IR   = 16'h0000;

    localparam logic [1:0]  FWD_RF   = 2'd0;
    localparam logic [1:0]  FWD_ALU  = 2'd1;
    localparam logic [1:0]  FWD_WB   = 2'd2;

    typedef enum logic [1:0] {
        ST_ISSUE,
        ST_MLT_WAIT,
        ST_BR_WAIT
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] dest;
    } sb_entry_t;

    function automatic logic is_branch(input logic [15:0] ir);
        return ir[15:14] == CLS_BR;
    endfunction

    function automatic logic is_mlt(input logic [15:0] ir);
        return (ir[15:14] == CLS_R) && (ir[4:0] == FUNC_MLT);
    endfunction

    function automatic logic is_writer(input logic [15:0] ir);
        logic r_writer;
        r_writer = (ir[15:14] == CLS_R) &&
                   ((ir[4:0] == FUNC_ADD) || (ir[4:0] == FUNC_CMP) || (ir[4:0] == FUNC_MLT));
        return r_writer || (ir[15:14] == CLS_LI);
    endfunction

    // Only conditional branches read a register; B carries no source.
    function automatic logic has_src1(input logic [15:0] ir);
        return (ir[15:14] == CLS_R) ||
               ((ir[15:14] == CLS_BR) && ((ir[13:11] == BR_BNZ) || (ir[13:11] == BR_BZ)));
    endfunction

    function automatic logic has_src2(input logic [15:0] ir);
        return ir[15:14] == CLS_R;
    endfunction

endpackage

// File: rtl/alu_scoreboard.sv
// Two-entry destination history (EX, WB) and the per-source match logic that
// produces the registered forwarding selects for the instruction entering the ALU.
module alu_scoreboard
    import cpu_pkg::*;
#(
    parameter logic [15:0] NOP = NOP_IR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_hold,
    input  logic [15:0] i_ir,
    output logic [1:0]  o_fwd_sel1,
    output logic [1:0]  o_fwd_sel2
);

    sb_entry_t r_ex;
    sb_entry_t r_wb;
    logic      w_issue;

    assign w_issue = i_load && (i_ir != NOP);

    // While an MLT occupies the ALU it stays the youngest producer; older results retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex <= '0;
            r_wb <= '0;
        end else if (i_hold) begin
            r_wb <= '0;
        end else begin
            r_wb       <= r_ex;
            r_ex.valid <= w_issue && is_writer(i_ir);
            r_ex.dest  <= i_ir[13:11];
        end
    end

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_src
        logic [2:0] w_src;
        logic       w_used;
        logic [1:0] w_sel_next;
        logic [1:0] r_sel;

        assign w_src  = (gi == 0) ? i_ir[10:8] : i_ir[7:5];
        assign w_used = (gi == 0) ? has_src1(i_ir) : has_src2(i_ir);

        always_comb begin
            w_sel_next = FWD_RF;
            if (w_issue && w_used) begin
                if (r_ex.valid && (r_ex.dest == w_src)) begin
                    w_sel_next = FWD_ALU;
                end else if (r_wb.valid && (r_wb.dest == w_src)) begin
                    w_sel_next = FWD_WB;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sel <= FWD_RF;
            end else if (!i_hold) begin
                r_sel <= w_sel_next;
            end
        end
    end

    assign o_fwd_sel1 = g_src[0].r_sel;
    assign o_fwd_sel2 = g_src[1].r_sel;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Decode-to-ALU issue controller: valid/ready intake, MLT occupancy stall,
// branch-resolution bubble with flush pulse, and operand forwarding selects.
module alu_issue_ctrl
    import cpu_pkg::*;
#(
    parameter int          MLT_LAT = 3,
    parameter logic [15:0] NOP     = NOP_IR
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [15:0] in_ir,
    output logic        in_ready,
    output logic [15:0] alu_ir,
    output logic [1:0]  fwd_sel1,
    output logic [1:0]  fwd_sel2,
    input  logic        br_resolve,
    input  logic        br_taken,
    output logic        flush,
    output logic        busy
);

    localparam int CW = $clog2(MLT_LAT + 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [15:0]   r_alu_ir;
    logic [15:0]   w_alu_ir_next;
    logic          r_ready_en;
    logic          w_xfer;
    logic          w_hold;

    // Intake stays closed until the first clock after reset release.
    assign in_ready = r_ready_en && (r_state == ST_ISSUE);
    assign w_xfer   = in_valid && in_ready;
    assign w_hold   = (r_state == ST_MLT_WAIT);
    assign busy     = (r_state != ST_ISSUE);
    assign alu_ir   = r_alu_ir;

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_alu_ir_next = NOP;
        flush         = 1'b0;
        case (r_state)
            ST_ISSUE: begin
                if (w_xfer) begin
                    w_alu_ir_next = in_ir;
                    if (is_branch(in_ir)) begin
                        w_state_next = ST_BR_WAIT;
                    end else if (is_mlt(in_ir) && (MLT_LAT > 1)) begin
                        w_state_next = ST_MLT_WAIT;
                        w_cnt_next   = CW'(MLT_LAT - 1);
                    end
                end
            end
            ST_MLT_WAIT: begin
                w_alu_ir_next = r_alu_ir;
                w_cnt_next    = r_cnt - 1'b1;
                if (r_cnt <= CW'(1)) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_BR_WAIT: begin
                if (br_resolve) begin
                    w_state_next = ST_ISSUE;
                    flush        = br_taken;
                end
            end
            default: w_state_next = ST_ISSUE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_ISSUE;
            r_cnt      <= '0;
            r_alu_ir   <= NOP;
            r_ready_en <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_alu_ir   <= w_alu_ir_next;
            r_ready_en <= 1'b1;
        end
    end

    alu_scoreboard #(
        .NOP(NOP)
    ) u_scoreboard (
        .clk       (CLK),
        .rst       (RST),
        .i_load    (w_xfer),
        .i_hold    (w_hold),
        .i_ir      (in_ir),
        .o_fwd_sel1(fwd_sel1),
        .o_fwd_sel2(fwd_sel2)
    );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: hand-computed vector table, reset-during-MLT
// sequence, then random traffic checked against a slot-history reference model.
module tb_alu_issue_ctrl;

    localparam int          MLT_LAT = 3;
    localparam logic [15:0] NOP     = 16'h0000;

    logic        CLK        = 1'b0;
    logic        RST        = 1'b1;
    logic        in_valid   = 1'b0;
    logic [15:0] in_ir      = 16'h0000;
    logic        br_resolve = 1'b0;
    logic        br_taken   = 1'b0;
    logic        in_ready;
    logic [15:0] alu_ir;
    logic [1:0]  fwd_sel1;
    logic [1:0]  fwd_sel2;
    logic        flush;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: destinations written by the last two ALU slots (index 1 = newest).
    int          m_q[2];
    bit          m_br;
    int          m_mlt_left;
    logic [15:0] m_alu;
    int          m_f1;
    int          m_f2;
    bit          obs_ready;
    bit          obs_flush;

    typedef struct {
        bit          v;
        logic [15:0] ir;
        bit          res;
        bit          tk;
        bit          e_rdy;
        bit          e_fl;
        logic [15:0] e_alu;
        int          e_f1;
        int          e_f2;
        bit          e_busy;
    } vec_t;

    vec_t vecs[$];

    always #5 CLK = ~CLK;

    alu_issue_ctrl #(
        .MLT_LAT(MLT_LAT),
        .NOP    (NOP)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ir     (in_ir),
        .in_ready  (in_ready),
        .alu_ir    (alu_ir),
        .fwd_sel1  (fwd_sel1),
        .fwd_sel2  (fwd_sel2),
        .br_resolve(br_resolve),
        .br_taken  (br_taken),
        .flush     (flush),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int dest_of(input logic [15:0] ir);
        logic [4:0] fn;
        fn = ir[4:0];
        if (ir == NOP) return -1;
        if (ir[15:14] == 2'b01) return int'(ir[13:11]);
        if (ir[15:14] == 2'b00 && (fn == 5'd2 || fn == 5'd4 || fn == 5'd5)) return int'(ir[13:11]);
        return -1;
    endfunction

    function automatic int sel_for(input int src);
        if (m_q[1] == src) return 1;
        if (m_q[0] == src) return 2;
        return 0;
    endfunction

    function automatic void model_reset();
        m_q        = '{-1, -1};
        m_br       = 1'b0;
        m_mlt_left = 0;
        m_alu      = NOP;
        m_f1       = 0;
        m_f2       = 0;
    endfunction

    task automatic step(input bit v, input logic [15:0] ir, input bit res, input bit tk);
        bit e_ready;
        bit e_flush;
        bit xfer;
        bit use1;
        bit use2;
        @(negedge CLK);
        in_valid   = v;
        in_ir      = ir;
        br_resolve = res;
        br_taken   = tk;
        e_ready    = !m_br && (m_mlt_left == 0);
        e_flush    = m_br && res && tk;
        #1;
        obs_ready = in_ready;
        obs_flush = flush;
        chk("in_ready", 16'(in_ready), 16'(e_ready));
        chk("flush", 16'(flush), 16'(e_flush));
        xfer = v && e_ready;
        if (m_mlt_left > 0) begin
            m_mlt_left--;
            m_q = '{-1, m_q[1]};
        end else if (m_br) begin
            m_alu = NOP;
            m_f1  = 0;
            m_f2  = 0;
            if (res) m_br = 1'b0;
            m_q = '{m_q[1], -1};
        end else if (xfer) begin
            use1  = (ir[15:14] == 2'b00) ||
                    (ir[15:14] == 2'b10 && (ir[13:11] == 3'd1 || ir[13:11] == 3'd2));
            use2  = (ir[15:14] == 2'b00);
            m_alu = ir;
            m_f1  = (use1 && ir != NOP) ? sel_for(int'(ir[10:8])) : 0;
            m_f2  = (use2 && ir != NOP) ? sel_for(int'(ir[7:5])) : 0;
            m_q   = '{m_q[1], dest_of(ir)};
            if (ir[15:14] == 2'b10) m_br = 1'b1;
            else if (ir[15:14] == 2'b00 && ir[4:0] == 5'd5 && MLT_LAT > 1) m_mlt_left = MLT_LAT - 1;
        end else begin
            m_alu = NOP;
            m_f1  = 0;
            m_f2  = 0;
            m_q   = '{m_q[1], -1};
        end
        @(posedge CLK);
        #1;
        chk("alu_ir", alu_ir, m_alu);
        chk("fwd_sel1", 16'(fwd_sel1), 16'(m_f1));
        chk("fwd_sel2", 16'(fwd_sel2), 16'(m_f2));
        chk("busy", 16'(busy), 16'(m_br || (m_mlt_left > 0)));
        $display("t=%0t v=%0b ir=%h res=%0b tk=%0b rdy=%0b fl=%0b -> alu_ir=%h sel=%0d/%0d busy=%0b",
                 $time, v, ir, res, tk, obs_ready, obs_flush, alu_ir, fwd_sel1, fwd_sel2, busy);
    endtask

    function automatic void add_vec(input bit v, input logic [15:0] ir, input bit res, input bit tk,
                                    input bit e_rdy, input bit e_fl, input logic [15:0] e_alu,
                                    input int e_f1, input int e_f2, input bit e_busy);
        vec_t r;
        r = '{v, ir, res, tk, e_rdy, e_fl, e_alu, e_f1, e_f2, e_busy};
        vecs.push_back(r);
    endfunction

    function automatic logic [15:0] rand_ir();
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] c;
        logic [4:0] fn;
        int         k;
        a = 3'($urandom_range(0, 3));
        b = 3'($urandom_range(0, 3));
        c = 3'($urandom_range(0, 3));
        k = $urandom_range(0, 9);
        case ($urandom_range(0, 3))
            0:       fn = 5'd2;
            1:       fn = 5'd4;
            2:       fn = 5'd5;
            default: fn = 5'd1;
        endcase
        if (k <= 4) return {2'b00, a, b, c, fn};
        if (k <= 6) return {2'b01, a, 11'($urandom)};
        if (k == 7) return {2'b10, 3'b010, b, 8'h00};
        if (k == 8) return {2'b10, 3'b001, b, 8'h00};
        return 16'h8000;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //       v  ir        res tk rdy fl alu       f1 f2 busy
        add_vec(1, 16'h0822, 0, 0, 1, 0, 16'h0822, 0, 0, 0); // ADD r1=r0+r1
        add_vec(1, 16'h1122, 0, 0, 1, 0, 16'h1122, 1, 1, 0); // ADD r2=r1+r1
        add_vec(1, 16'h1902, 0, 0, 1, 0, 16'h1902, 2, 0, 0); // ADD r3=r1+r0
        add_vec(1, 16'h2A62, 0, 0, 1, 0, 16'h2A62, 2, 1, 0); // ADD r5=r2+r3
        add_vec(1, 16'h5800, 0, 0, 1, 0, 16'h5800, 0, 0, 0); // LI r3
        add_vec(0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
        add_vec(1, 16'h3362, 0, 0, 1, 0, 16'h3362, 2, 2, 0); // ADD r6=r3+r3, one gap
        add_vec(1, 16'h5800, 0, 0, 1, 0, 16'h5800, 0, 0, 0);
        add_vec(0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
        add_vec(0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
        add_vec(1, 16'h3362, 0, 0, 1, 0, 16'h3362, 0, 0, 0); // two gaps
        add_vec(1, 16'h3B25, 0, 0, 1, 0, 16'h3B25, 0, 0, 1); // MLT r7=r3*r1
        add_vec(1, 16'h0822, 0, 0, 0, 0, 16'h3B25, 0, 0, 1);
        add_vec(1, 16'h0822, 0, 0, 0, 0, 16'h3B25, 0, 0, 0);
        add_vec(1, 16'h17E2, 0, 0, 1, 0, 16'h17E2, 1, 1, 0); // ADD r2=r7+r7
        add_vec(1, 16'h9200, 0, 0, 1, 0, 16'h9200, 1, 0, 1); // BZ r2
        add_vec(1, 16'h0822, 0, 0, 0, 0, 16'h0000, 0, 0, 1);
        add_vec(1, 16'h0822, 0, 0, 0, 0, 16'h0000, 0, 0, 1);
        add_vec(0, 16'h0000, 1, 1, 0, 1, 16'h0000, 0, 0, 0); // taken
        add_vec(0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
        add_vec(1, 16'h8800, 0, 0, 1, 0, 16'h8800, 0, 0, 1); // BNZ r0
        add_vec(0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 0); // not taken
        add_vec(0, 16'h0000, 1, 1, 1, 0, 16'h0000, 0, 0, 0); // stray resolve
        add_vec(1, 16'h0822, 1, 1, 1, 0, 16'h0822, 0, 0, 0);
        add_vec(1, 16'h8000, 0, 0, 1, 0, 16'h8000, 0, 0, 1); // B
        add_vec(0, 16'h0000, 1, 1, 0, 1, 16'h0000, 0, 0, 0);

        model_reset();
        @(posedge CLK);
        #1;
        chk("rst_alu_ir", alu_ir, NOP);
        chk("rst_fwd1", 16'(fwd_sel1), 16'd0);
        chk("rst_fwd2", 16'(fwd_sel2), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_flush", 16'(flush), 16'd0);
        chk("rst_ready", 16'(in_ready), 16'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("ready_after_rst", 16'(in_ready), 16'd1);

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].ir, vecs[i].res, vecs[i].tk);
            chk($sformatf("vec%0d_rdy", i), 16'(obs_ready), 16'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_fl", i), 16'(obs_flush), 16'(vecs[i].e_fl));
            chk($sformatf("vec%0d_alu", i), alu_ir, vecs[i].e_alu);
            chk($sformatf("vec%0d_f1", i), 16'(fwd_sel1), 16'(vecs[i].e_f1));
            chk($sformatf("vec%0d_f2", i), 16'(fwd_sel2), 16'(vecs[i].e_f2));
            chk($sformatf("vec%0d_busy", i), 16'(busy), 16'(vecs[i].e_busy));
        end

        // Reset asserted while the MLT still occupies the ALU.
        step(1, 16'h3B25, 0, 0);
        @(negedge CLK);
        in_valid = 1'b0;
        RST      = 1'b1;
        #1;
        chk("midmlt_alu_ir", alu_ir, NOP);
        chk("midmlt_busy", 16'(busy), 16'd0);
        chk("midmlt_flush", 16'(flush), 16'd0);
        chk("midmlt_ready", 16'(in_ready), 16'd0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        chk("midmlt_ready_rel", 16'(in_ready), 16'd1);
        chk("midmlt_alu_rel", alu_ir, NOP);

        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 9) < 7), rand_ir(),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        @(negedge CLK);
        in_valid   = 1'b0;
        br_resolve = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
